// File: rtl/twenty_bit_operand_fetch.sv
// Operand-fetch stage for the 20-bit logic units.
// Holds a DEPTH x WIDTH register file (register 0 reads as zero) with two
// read ports and one write port. It presents a registered operand pair to
// the logic unit and supports write-first bypass, stall hold, and refresh
// of held operands while stalled.
module twenty_bit_operand_fetch #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic [AW-1:0]    ra0,
   input  logic [AW-1:0]    ra1,
   input  logic             stall,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] op0,
   output logic [WIDTH-1:0] op1,
   output logic             op_valid
);

   logic [WIDTH-1:0] rf [DEPTH];
   logic [AW-1:0]    lat_ra0;
   logic [AW-1:0]    lat_ra1;

   logic             wr_hit;
   logic [WIDTH-1:0] rd_val0;
   logic [WIDTH-1:0] rd_val1;
   logic             refresh0;
   logic             refresh1;

   // A write is effective only to a nonzero address.
   assign wr_hit = we && (wa != '0);

   // Read-port values with write-first bypass; address 0 always reads zero.
   always_comb begin
      rd_val0 = '0;
      rd_val1 = '0;
      if (ra0 != '0) begin
         if (wr_hit && (wa == ra0)) begin
            rd_val0 = wd;
         end else begin
            rd_val0 = rf[ra0];
         end
      end
      if (ra1 != '0) begin
         if (wr_hit && (wa == ra1)) begin
            rd_val1 = wd;
         end else begin
            rd_val1 = rf[ra1];
         end
      end
   end

   // Refresh of a held operand when a write lands on its latched address.
   always_comb begin
      refresh0 = wr_hit && (wa == lat_ra0);
      refresh1 = wr_hit && (wa == lat_ra1);
   end

   // Register file write port; entry 0 is never written so it stays zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            rf[i] <= '0;
         end
      end else if (wr_hit) begin
         rf[wa] <= wd;
      end
   end

   // Operand registers: load on read, hold/refresh on stall, drop valid when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         op0      <= '0;
         op1      <= '0;
         op_valid <= 1'b0;
         lat_ra0  <= '0;
         lat_ra1  <= '0;
      end else if (stall) begin
         if (refresh0) begin
            op0 <= wd;
         end
         if (refresh1) begin
            op1 <= wd;
         end
      end else if (rd_en) begin
         op0      <= rd_val0;
         op1      <= rd_val1;
         op_valid <= 1'b1;
         lat_ra0  <= ra0;
         lat_ra1  <= ra1;
      end else begin
         op_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_twenty_bit_operand_fetch.sv
// Scoreboard bench for twenty_bit_operand_fetch: a driver applies directed
// and random cycles, a reference model predicts the operand outputs and
// queues them, and a monitor compares the DUT outputs each cycle.
module tb_twenty_bit_operand_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_en = 1'b0;
   logic [3:0]  ra0 = '0;
   logic [3:0]  ra1 = '0;
   logic        stall = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  wa = '0;
   logic [19:0] wd = '0;
   logic [19:0] op0;
   logic [19:0] op1;
   logic        op_valid;

   twenty_bit_operand_fetch #(.WIDTH(20), .DEPTH(16), .AW(4)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .ra0(ra0), .ra1(ra1),
      .stall(stall), .we(we), .wa(wa), .wd(wd),
      .op0(op0), .op1(op1), .op_valid(op_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [19:0] e0;
      logic [19:0] e1;
      logic        ev;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state
   logic [19:0] m_mem [16];
   logic [19:0] m_op0 = '0;
   logic [19:0] m_op1 = '0;
   logic        m_v = 1'b0;
   logic [3:0]  m_la0 = '0;
   logic [3:0]  m_la1 = '0;

   // Value a read port sees this cycle under the write-first rule.
   function automatic logic [19:0] model_read(input logic [3:0] a);
      if (a == 4'd0) return 20'd0;
      if (we && wa == a) return wd;
      return m_mem[a];
   endfunction

   // Apply one clock edge of the specification's rules to the model.
   task automatic model_edge();
      logic [19:0] n0, n1;
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_op0 = '0; m_op1 = '0; m_v = 1'b0; m_la0 = '0; m_la1 = '0;
      end else begin
         if (stall) begin
            if (we && wa != 4'd0 && wa == m_la0) m_op0 = wd;
            if (we && wa != 4'd0 && wa == m_la1) m_op1 = wd;
         end else if (rd_en) begin
            n0 = model_read(ra0);
            n1 = model_read(ra1);
            m_op0 = n0; m_op1 = n1; m_v = 1'b1;
            m_la0 = ra0; m_la1 = ra1;
         end else begin
            m_v = 1'b0;
         end
         if (we && wa != 4'd0) m_mem[wa] = wd;
      end
      exp_q.push_back('{e0: m_op0, e1: m_op1, ev: m_v});
   endtask

   task automatic cycle(input logic r, input logic w, input logic [3:0] a,
                        input logic [19:0] d, input logic re, input logic [3:0] a0,
                        input logic [3:0] a1, input logic s);
      @(negedge clk);
      rst = r; we = w; wa = a; wd = d; rd_en = re; ra0 = a0; ra1 = a1; stall = s;
      @(posedge clk);
      model_edge();
   endtask

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %05h expected %05h", name, act, req);
      end
   endtask

   // Monitor: compare DUT outputs against the queued prediction after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (op0 !== e.e0 || op1 !== e.e1 || op_valid !== e.ev) begin
               miscompares++;
               $display("FAIL scoreboard @%0t: got op0=%05h op1=%05h v=%b expected op0=%05h op1=%05h v=%b",
                        $time, op0, op1, op_valid, e.e0, e.e1, e.ev);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      foreach (m_mem[i]) m_mem[i] = '0;

      // Reset beats a same-cycle write
      cycle(1, 1, 4'd3, 20'hABCDE, 0, 4'd0, 4'd0, 0);
      cycle(1, 1, 4'd3, 20'hABCDE, 0, 4'd0, 4'd0, 0);
      #2;
      check("reset_valid", {19'd0, op_valid}, 20'd0);
      check("reset_op0", op0, 20'd0);
      check("reset_op1", op1, 20'd0);
      cycle(0, 0, 4'd0, 20'd0, 1, 4'd3, 4'd3, 0);
      #2;
      check("reg3_after_reset", op0, 20'd0);

      // Basic read after writes
      cycle(0, 1, 4'd1, 20'h0005F, 0, 4'd0, 4'd0, 0);
      cycle(0, 1, 4'd2, 20'hC0003, 0, 4'd0, 4'd0, 0);
      cycle(0, 0, 4'd0, 20'd0, 1, 4'd1, 4'd2, 0);
      #2;
      check("read_op0", op0, 20'h0005F);
      check("read_op1", op1, 20'hC0003);
      check("read_valid", {19'd0, op_valid}, 20'd1);
      check("or_result", op0 | op1, 20'hC005F);

      // Write-first bypass on both ports
      cycle(0, 1, 4'd5, 20'hFFFFF, 1, 4'd5, 4'd5, 0);
      #2;
      check("bypass_op0", op0, 20'hFFFFF);
      check("bypass_op1", op1, 20'hFFFFF);

      // Register 0 stays zero
      cycle(0, 1, 4'd0, 20'h12345, 0, 4'd0, 4'd0, 0);
      cycle(0, 0, 4'd0, 20'd0, 1, 4'd0, 4'd1, 0);
      #2;
      check("r0_read", op0, 20'd0);
      cycle(0, 1, 4'd0, 20'h12345, 1, 4'd0, 4'd0, 0);
      #2;
      check("r0_bypass", op0, 20'd0);

      // Stall refresh
      cycle(0, 1, 4'd4, 20'h00001, 0, 4'd0, 4'd0, 0);
      cycle(0, 1, 4'd6, 20'h00777, 0, 4'd0, 4'd0, 0);
      cycle(0, 0, 4'd0, 20'd0, 1, 4'd4, 4'd6, 0);
      #2;
      check("pre_stall_op0", op0, 20'h00001);
      cycle(0, 1, 4'd4, 20'h80000, 1, 4'd1, 4'd2, 1);
      #2;
      check("refresh_op0", op0, 20'h80000);
      check("refresh_op1", op1, 20'h00777);
      check("refresh_valid", {19'd0, op_valid}, 20'd1);
      cycle(0, 0, 4'd0, 20'd0, 1, 4'd1, 4'd2, 1);
      #2;
      check("stall_ignore_rd", op0, 20'h80000);

      // Reset during stall
      cycle(1, 0, 4'd0, 20'd0, 1, 4'd1, 4'd2, 1);
      #2;
      check("rst_stall_valid", {19'd0, op_valid}, 20'd0);
      check("rst_stall_op0", op0, 20'd0);
      cycle(0, 0, 4'd0, 20'd0, 1, 4'd1, 4'd6, 0);
      #2;
      check("post_rst_op0", op0, 20'd0);
      check("post_rst_op1", op1, 20'd0);

      // Random traffic; narrow address range on some cycles to provoke bypass/refresh hits
      for (int i = 0; i < 800; i++) begin
         logic        r, w, re, s;
         logic [3:0]  a, a0, a1;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 25);
         re = ($urandom_range(0, 99) < 65);
         w  = ($urandom_range(0, 99) < 55);
         if ($urandom_range(0, 1) == 0) begin
            a  = 4'($urandom_range(0, 3));
            a0 = 4'($urandom_range(0, 3));
            a1 = 4'($urandom_range(0, 3));
         end else begin
            a  = 4'($urandom_range(0, 15));
            a0 = 4'($urandom_range(0, 15));
            a1 = 4'($urandom_range(0, 15));
         end
         cycle(r, w, a, 20'($urandom), re, a0, a1, s);
      end

      cycle(0, 0, 4'd0, 20'd0, 0, 4'd0, 4'd0, 0);
      #3;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/twenty_bit_operand_fetch.md
Name: twenty_bit_operand_fetch

Overview:
- Operand-fetch stage sitting directly upstream of the 20-bit logic units (bitwise OR and siblings).
- Holds a 16-entry x 20-bit register file with two read ports and one write port.
- Delivers two registered operands (op0 → i0, op1 → i1) plus a valid flag to the logic unit; accepts write-back of results.
- Supports stall hold, write-to-read bypass, and operand refresh while stalled.

Parameters:
WIDTH, 20, operand/register data width
DEPTH, 16, number of registers
AW, 4, register address width (DEPTH = 2**AW)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
rd_en  input  1  read request; captures ra0/ra1 this cycle
ra0  input  AW  read address for operand 0
ra1  input  AW  read address for operand 1
stall  input  1  downstream not ready; hold current operands
we  input  1  write enable
wa  input  AW  write address
wd  input  WIDTH  write data (result from logic unit)
op0  output  WIDTH  registered operand 0 (drives i0 of the logic unit)
op1  output  WIDTH  registered operand 1 (drives i1 of the logic unit)
op_valid  output  1  op0/op1 hold a valid operand pair

Behaviour:
- Reset (rst=1 at a rising edge):
  - all DEPTH registers cleared to 0; op0=op1=0; op_valid=0; latched addresses=0.
  - rst has priority over we, rd_en and stall in the same cycle.
- Register 0 is hardwired zero:
  - writes with wa=0 are ignored.
  - reads of address 0 always return 0, including through the bypass.
- Write: we=1 and wa≠0 → reg[wa] <= wd at the edge. Writes proceed regardless of stall.
- Read, stall=0:
  - rd_en=1 → op0 <= value(ra0), op1 <= value(ra1), op_valid <= 1, latch ra0/ra1 internally.
  - rd_en=0 → op_valid <= 0; op0/op1 keep their last values.
- Read latency: 1 cycle (address at edge N, operands visible after edge N).
- Bypass (write-first):
  - value(ra) = wd when we=1, wa=ra and ra≠0; otherwise reg[ra].
  - Applies independently to each port; ra0=ra1 with a bypass hit gives both ports wd.
- Stall=1:
  - rd_en, ra0 and ra1 are ignored; upstream must hold the request.
  - op_valid is held.
  - Refresh rule: if we=1, wa≠0 and wa equals a latched address, the matching op register is updated to wd. Both ports update if both match. Other op registers hold.
- Stall released: normal read behaviour resumes on the next edge; no duplicate or lost op_valid beyond what rd_en/stall dictate.
- Reset mid-stall or mid-read: the pending pair is discarded; op_valid=0 on the cycle after reset.
- All outputs come from registers; no combinational path from inputs to outputs.

Test Plan:
1. Reset with we=1, wa=3, wd=20'hABCDE in the same cycle → op_valid=0, op0=op1=0; a later read of reg 3 returns 0.
2. Write reg1=20'h0005F, reg2=20'hC0003; next cycle rd_en with ra0=1, ra1=2 → one cycle later op0=20'h0005F, op1=20'hC0003, op_valid=1. Downstream OR output = 20'hC005F.
3. Bypass: we=1, wa=5, wd=20'hFFFFF with rd_en=1, ra0=5, ra1=5 in the same cycle → op0=op1=20'hFFFFF next cycle.
4. Register 0: we=1, wa=0, wd=20'h12345, then read ra0=0 → op0=0; same-cycle write+read of address 0 → op0=0.
5. Stall refresh: latch ra0=4 (value 20'h00001), ra1=6; assert stall; write wa=4, wd=20'h80000 → op0=20'h80000, op1 unchanged, op_valid stays 1; rd_en with new addresses during stall is ignored.
6. Reset asserted while stall=1 and op_valid=1 → next cycle op_valid=0, op0=op1=0; after deassert, read of any nonzero register returns 0.
